scope_capture: RTL

- Capture stage directly downstream of the 8-channel ADC controller. Consumes its free-running 12-bit CH0..CH7 outputs.
- Decimates the selected channel to a fixed sample rate and detects a level-crossing trigger.
- Stores a pre/post-trigger window in a circular buffer and presents it as a linear, trigger-aligned record for the display/readout logic.

---
 rtl/scope_pkg.sv | 18 +
 rtl/scope_capture_ram.sv | 26 ++
 rtl/scope_capture.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/scope_pkg.sv
// Shared constants and state encoding for the scope capture block.
package scope_pkg;

  localparam int ADC_W  = 12;
  localparam int NUM_CH = 8;

  localparam logic EDGE_RISE = 1'b0;
  localparam logic EDGE_FALL = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PREFILL   = 3'd1,
    ST_WAIT_TRIG = 3'd2,
    ST_POST      = 3'd3,
    ST_DONE      = 3'd4
  } state_t;

endpackage

// File: rtl/scope_capture_ram.sv
// Simple dual-port sample memory: one write port, one registered read port.
module scope_capture_ram
  import scope_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int DATA_W = ADC_W
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/scope_capture.sv
// Decimating trigger/capture stage with a trigger-aligned circular record.
// Define SCOPE_CAPTURE_HYST_EN to require the previous sample to clear a HYST band.
module scope_capture
  import scope_pkg::*;
#(
  parameter int DEPTH_LOG2 = 9,
  parameter int PRE_TRIG   = 128,
  parameter int SAMPLE_DIV = 50,
  parameter int HYST       = 8
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  input  logic [ADC_W-1:0]      CH0,
  input  logic [ADC_W-1:0]      CH1,
  input  logic [ADC_W-1:0]      CH2,
  input  logic [ADC_W-1:0]      CH3,
  input  logic [ADC_W-1:0]      CH4,
  input  logic [ADC_W-1:0]      CH5,
  input  logic [ADC_W-1:0]      CH6,
  input  logic [ADC_W-1:0]      CH7,
  input  logic [2:0]            CH_SEL,
  input  logic [ADC_W-1:0]      TRIG_LEVEL,
  input  logic                  TRIG_EDGE,
  input  logic                  ARM,
  input  logic                  FORCE,
  input  logic [DEPTH_LOG2-1:0] RD_ADDR,
  output logic [ADC_W-1:0]      RD_DATA,
  output logic                  BUSY,
  output logic                  DONE
);

`ifdef SCOPE_CAPTURE_HYST_EN
  localparam bit HYST_EN = 1'b1;
`else
  localparam bit HYST_EN = 1'b0;
`endif

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = DEPTH_LOG2 + 1;
  localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  localparam logic [DIV_W-1:0]      DIV_LAST   = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [CNT_W-1:0]      PRE_TRIG_C = CNT_W'(PRE_TRIG);
  localparam logic [CNT_W-1:0]      POST_LEN_C = CNT_W'(DEPTH - PRE_TRIG);
  localparam logic [DEPTH_LOG2-1:0] PRE_TRIG_A = DEPTH_LOG2'(PRE_TRIG);
  localparam logic [ADC_W-1:0]      BAND       = HYST_EN ? ADC_W'(HYST) : {ADC_W{1'b0}};

  function automatic logic [ADC_W-1:0] sat_sub(input logic [ADC_W-1:0] a,
                                               input logic [ADC_W-1:0] b);
    return (a >= b) ? (a - b) : {ADC_W{1'b0}};
  endfunction

  function automatic logic [ADC_W-1:0] sat_add(input logic [ADC_W-1:0] a,
                                               input logic [ADC_W-1:0] b);
    logic [ADC_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[ADC_W] ? {ADC_W{1'b1}} : s[ADC_W-1:0];
  endfunction

  state_t                  state_q;
  logic [2:0]              sel_q;
  logic [ADC_W-1:0]        level_q;
  logic                    edge_q;
  logic [DIV_W-1:0]        div_q;
  logic [DEPTH_LOG2-1:0]   wr_ptr_q;
  logic [DEPTH_LOG2-1:0]   trig_ptr_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [CNT_W-1:0]        cnt_nxt;
  logic                    prev_valid_q;
  logic                    rd_zero_q;
  logic [ADC_W-1:0]        prev_q;
  logic [ADC_W-1:0]        sample;
  logic [ADC_W-1:0]        lo_band;
  logic [ADC_W-1:0]        hi_band;
  logic                    busy;
  logic                    tick;
  logic                    rise_hit;
  logic                    fall_hit;
  logic                    trig_hit;
  logic                    wr_en;
  logic [DEPTH_LOG2-1:0]   rd_addr_p0;
  logic [ADC_W-1:0]        rd_data_p1;

  always_comb begin
    sample = CH0;
    case (sel_q)
      3'd0: sample = CH0;
      3'd1: sample = CH1;
      3'd2: sample = CH2;
      3'd3: sample = CH3;
      3'd4: sample = CH4;
      3'd5: sample = CH5;
      3'd6: sample = CH6;
      3'd7: sample = CH7;
      default: sample = CH0;
    endcase
  end

  assign busy    = (state_q == ST_PREFILL) || (state_q == ST_WAIT_TRIG) || (state_q == ST_POST);
  assign tick    = busy && (div_q == DIV_LAST);
  assign cnt_nxt = cnt_q + 1'b1;

  // With BAND = 0 the rising test reduces to prev < level <= cur.
  assign lo_band  = sat_sub(level_q, BAND);
  assign hi_band  = sat_add(level_q, BAND);
  assign rise_hit = (prev_q < lo_band) && (sample >= level_q);
  assign fall_hit = (HYST_EN ? (prev_q > hi_band) : (prev_q >= level_q)) && (sample < level_q);
  assign trig_hit = prev_valid_q && (FORCE || ((edge_q == EDGE_FALL) ? fall_hit : rise_hit));

  assign wr_en = tick && !ARM && !RESET;

  always_ff @(posedge CLOCK) begin
    if (tick) prev_q <= sample;
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q      <= ST_IDLE;
      sel_q        <= '0;
      level_q      <= '0;
      edge_q       <= EDGE_RISE;
      div_q        <= '0;
      wr_ptr_q     <= '0;
      trig_ptr_q   <= '0;
      cnt_q        <= '0;
      prev_valid_q <= 1'b0;
      rd_zero_q    <= 1'b1;
    end else begin
      rd_zero_q <= 1'b0;
      if (ARM) begin
        state_q      <= (PRE_TRIG == 0) ? ST_WAIT_TRIG : ST_PREFILL;
        sel_q        <= CH_SEL;
        level_q      <= TRIG_LEVEL;
        edge_q       <= TRIG_EDGE;
        div_q        <= '0;
        wr_ptr_q     <= '0;
        cnt_q        <= '0;
        prev_valid_q <= 1'b0;
      end else begin
        if (busy) div_q <= tick ? '0 : div_q + 1'b1;
        if (tick) begin
          wr_ptr_q     <= wr_ptr_q + 1'b1;
          prev_valid_q <= 1'b1;
          case (state_q)
            ST_PREFILL: begin
              cnt_q <= cnt_nxt;
              if (cnt_nxt == PRE_TRIG_C) state_q <= ST_WAIT_TRIG;
            end
            ST_WAIT_TRIG: begin
              if (trig_hit) begin
                trig_ptr_q <= wr_ptr_q;
                cnt_q      <= {{(CNT_W-1){1'b0}}, 1'b1};
                state_q    <= (POST_LEN_C == 1) ? ST_DONE : ST_POST;
              end
            end
            ST_POST: begin
              cnt_q <= cnt_nxt;
              if (cnt_nxt == POST_LEN_C) state_q <= ST_DONE;
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Read stage p0: logical index to physical address
  assign rd_addr_p0 = trig_ptr_q - PRE_TRIG_A + RD_ADDR;

  scope_capture_ram #(
    .ADDR_W (DEPTH_LOG2),
    .DATA_W (ADC_W)
  ) u_ram (
    .clk     (CLOCK),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_q),
    .wr_data (sample),
    .rd_addr (rd_addr_p0),
    .rd_data (rd_data_p1)
  );

  // Read stage p1: registered RAM output, forced to zero straight after reset
  assign RD_DATA = rd_zero_q ? {ADC_W{1'b0}} : rd_data_p1;
  assign BUSY    = busy;
  assign DONE    = (state_q == ST_DONE);

endmodule
